match_event_counter: RTL and testbench
======================================

Name: match_event_counter

Overview:
- Downstream consumer of the sequence detector's `ans` level output.
- Converts each entry into the matched state (rising edge of `ans`) into one event and accumulates events in a saturating counter.
- Exposes the count to a host through a four-phase req/ack read handshake with clear-on-read.
- Sits between the detector and the host/status logic.

Parameters:
- CNT_W, 8, width of the event counter and of every count output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ans_in  input  1  match level from the sequence detector.
- en  input  1  count enable; when low, edges are tracked but not counted.
- rd_req  input  1  host read request; level, four-phase.
- rd_ack  output  1  read acknowledge; high while snapshot is valid.
- rd_count  output  CNT_W  snapshot of event count taken at read.
- rd_ovf  output  1  snapshot of the sticky overflow flag taken at read.
- count_live  output  CNT_W  current running count.
- max_run  output  CNT_W  longest high run of ans_in; see Optional Feature.

Behaviour:
- Interface: one clock, `clk`. Reset is synchronous and active-high, port `reset`.
- Reset (sampled high at a clk edge) clears everything:
  - ans_q=0, count=0, ovf=0, rd_ack=0, rd_count=0, rd_ovf=0, max_run=0, run=0.
  - FSM goes to R_IDLE.
  - Reset overrides all other inputs in the same cycle, including mid-handshake; rd_ack drops the next cycle.
- Edge detect: ans_q<=ans_in every non-reset cycle, regardless of en.
  - event = ans_in & ~ans_q & en.
  - If ans_in is already high when reset releases, one event is counted on the first cycle, because ans_q=0.
  - If en rises while ans_in is held high, no event is counted.
- Counter: on event, count<=count+1.
  - At count = 2^CNT_W-1 the count holds and ovf<=1.
  - ovf is sticky until a read or reset.
- count_live = count register; it reflects an event one cycle after the edge.
- Read FSM, two states:
  - R_IDLE: rd_ack=0. When rd_req=1:
    - rd_count<=count and rd_ovf<=ovf. The snapshot is the pre-update value.
    - count and ovf clear. If an event occurs in the same cycle, count<=1 (the event is not lost).
    - Go to R_ACK.
  - R_ACK: rd_ack=1 and the snapshot registers are held.
    - Counting continues into count.
    - When rd_req=0, go to R_IDLE (rd_ack=0 the next cycle).
    - rd_req held high takes no new snapshot.
- Latency: rd_ack rises 1 cycle after rd_req is first sampled high. rd_count is valid in the same cycle rd_ack is high.
- A rd_req pulse of 1 cycle is legal: it gives one snapshot and one ack cycle, then returns to idle.

Optional Feature:
- Macro: MATCH_RUNLEN_EN.
- Defined:
  - run counts consecutive cycles with ans_in=1 (saturating at 2^CNT_W-1); it resets to 0 when ans_in=0.
  - maxr tracks the maximum of run; it is updated regardless of en.
  - The read snapshot loads max_run<=maxr and clears maxr.
  - If the run is still in progress at the snapshot, maxr restarts from the current run value.
- Undefined: the max_run port still exists and is tied to 0, keeping the interface stable. No run/maxr registers are built.

Decomposition:
- Shared header (`define` constants): R_IDLE=1'b0, R_ACK=1'b1, default CNT_W=8.
- One natural sub-module: rise_edge_det, holding ans_q and producing event from ans_in/en/reset.
- The counter and read FSM stay in the top module.

Test Plan:
- Reset, then ans_in pattern 0,1,1,0,1,0 with en=1 -> count_live reaches 2. rd_req pulse -> rd_ack=1 one cycle later, rd_count=2, rd_ovf=0, count_live=0.
- en=0 while ans_in rises, then en=1 while ans_in is still high -> count stays 0. Next 0->1 edge -> count=1.
- CNT_W=4: 17 rising edges -> count_live=15. Read -> rd_count=15, rd_ovf=1. A second read with no new events -> rd_count=0, rd_ovf=0.
- ans_in rising edge in the same cycle rd_req is sampled, with count=5 -> rd_count=5, count_live=1 afterward. Holding rd_req high 4 cycles -> rd_ack high the whole time, no re-snapshot.
- reset asserted while in R_ACK with count=3 -> next cycle rd_ack=0, rd_count=0, count_live=0. A new rd_req is served normally.
- MATCH_RUNLEN_EN defined: ans_in high runs of 3, then 7, then 2 cycles, then read -> max_run=7. Undefined: max_run=0 always.

Source files
------------

// File: rtl/match_event_counter_pkg.sv
// Shared constants and read-FSM state encoding for match_event_counter.
package match_event_counter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/match_event_counter_rise_edge_det.sv
// Rising-edge detector on the detector's ans level; emits a one-cycle event when enabled.
module match_event_counter_rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic ans_in,
    input  logic en,
    output logic evt
);

    logic r_ans_q;

    // ans_q tracks ans_in regardless of en, so enabling mid-high never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ans_q <= 1'b0;
        end else begin
            r_ans_q <= ans_in;
        end
    end

    assign evt = ans_in & ~r_ans_q & en & ~reset;

endmodule

// File: rtl/match_event_counter.sv
// Saturating match-event counter with four-phase clear-on-read host handshake.
// Optional run-length tracking on max_run is built when MATCH_RUNLEN_EN is defined.
module match_event_counter
    import match_event_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ans_in,
    input  logic             en,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_ovf,
    output logic [CNT_W-1:0] count_live,
    output logic [CNT_W-1:0] max_run
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_evt;
    logic             w_snap;
    rd_state_e        r_state;
    rd_state_e        w_state_d;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic             r_ovf;
    logic             w_ovf_d;
    logic [CNT_W-1:0] r_rd_count;
    logic             r_rd_ovf;

    match_event_counter_rise_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .ans_in (ans_in),
        .en     (en),
        .evt    (w_evt)
    );

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Read FSM: next state
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            R_IDLE:  if (rd_req)  w_state_d = R_ACK;
            R_ACK:   if (!rd_req) w_state_d = R_IDLE;
            default: w_state_d = R_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        rd_ack = (r_state == R_ACK);
        w_snap = (r_state == R_IDLE) && rd_req;
    end

    // A snapshot clears the counter, but a coincident event survives as count=1.
    always_comb begin
        w_count_d = r_count;
        w_ovf_d   = r_ovf;
        if (w_snap) begin
            w_count_d = w_evt ? CNT_W'(1) : '0;
            w_ovf_d   = 1'b0;
        end else if (w_evt) begin
            if (r_count == CNT_MAX) begin
                w_ovf_d = 1'b1;
            end else begin
                w_count_d = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_rd_count <= '0;
            r_rd_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_ovf   <= w_ovf_d;
            if (w_snap) begin
                r_rd_count <= r_count;
                r_rd_ovf   <= r_ovf;
            end
        end
    end

    assign count_live = r_count;
    assign rd_count   = r_rd_count;
    assign rd_ovf     = r_rd_ovf;

`ifdef MATCH_RUNLEN_EN
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] w_run_d;
    logic [CNT_W-1:0] r_maxr;
    logic [CNT_W-1:0] w_maxr_d;
    logic [CNT_W-1:0] r_max_run;

    // On a snapshot, maxr restarts from the run in progress (0 if ans_in is low).
    always_comb begin
        w_run_d = '0;
        if (ans_in) begin
            w_run_d = (r_run == CNT_MAX) ? r_run : r_run + CNT_W'(1);
        end
        w_maxr_d = (w_run_d > r_maxr) ? w_run_d : r_maxr;
        if (w_snap) begin
            w_maxr_d = w_run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run     <= '0;
            r_maxr    <= '0;
            r_max_run <= '0;
        end else begin
            r_run  <= w_run_d;
            r_maxr <= w_maxr_d;
            if (w_snap) begin
                r_max_run <= r_maxr;
            end
        end
    end

    assign max_run = r_max_run;
`else
    assign max_run = '0;
`endif

endmodule

// File: tb/tb_match_event_counter.sv
// Directed self-checking bench for match_event_counter (8-bit and 4-bit instances).
module tb_match_event_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ans_in;
    logic       en;
    logic       rd_req;

    logic       a_rd_ack;
    logic [7:0] a_rd_count;
    logic       a_rd_ovf;
    logic [7:0] a_count_live;
    logic [7:0] a_max_run;

    logic       b_rd_ack;
    logic [3:0] b_rd_count;
    logic       b_rd_ovf;
    logic [3:0] b_count_live;
    logic [3:0] b_max_run;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    match_event_counter #(.CNT_W(8)) u8 (
        .clk        (clk),
        .reset      (reset),
        .ans_in     (ans_in),
        .en         (en),
        .rd_req     (rd_req),
        .rd_ack     (a_rd_ack),
        .rd_count   (a_rd_count),
        .rd_ovf     (a_rd_ovf),
        .count_live (a_count_live),
        .max_run    (a_max_run)
    );

    match_event_counter #(.CNT_W(4)) u4 (
        .clk        (clk),
        .reset      (reset),
        .ans_in     (ans_in),
        .en         (en),
        .rd_req     (rd_req),
        .rd_ack     (b_rd_ack),
        .rd_count   (b_rd_count),
        .rd_ovf     (b_rd_ovf),
        .count_live (b_count_live),
        .max_run    (b_max_run)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic pulse_edges(input int n);
        for (int i = 0; i < n; i++) begin
            ans_in = 1'b1; tick();
            ans_in = 1'b0; tick();
        end
    endtask

    task automatic hold_ans(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            ans_in = v; tick();
        end
    endtask

    initial begin
        int exp_max;
        reset = 1'b1; ans_in = 1'b0; en = 1'b0; rd_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ack", int'(a_rd_ack), 0);
        chk("rst_rd_count", int'(a_rd_count), 0);
        chk("rst_rd_ovf", int'(a_rd_ovf), 0);
        chk("rst_count_live", int'(a_count_live), 0);
        chk("rst_max_run", int'(a_max_run), 0);

        // Pattern 0,1,1,0,1,0 -> two events, then single-cycle read pulse
        en = 1'b1;
        hold_ans(1'b0, 1); hold_ans(1'b1, 2); hold_ans(1'b0, 1);
        hold_ans(1'b1, 1); hold_ans(1'b0, 1);
        chk("pat_count_live", int'(a_count_live), 2);
        rd_req = 1'b1; tick();
        chk("pat_ack", int'(a_rd_ack), 1);
        chk("pat_rd_count", int'(a_rd_count), 2);
        chk("pat_rd_ovf", int'(a_rd_ovf), 0);
        chk("pat_cleared", int'(a_count_live), 0);
`ifdef MATCH_RUNLEN_EN
        exp_max = 2;
`else
        exp_max = 0;
`endif
        chk("pat_max_run", int'(a_max_run), exp_max);
        rd_req = 1'b0; tick();
        chk("pat_ack_drop", int'(a_rd_ack), 0);

        // Enable rising while ans_in is high must not count
        en = 1'b0; ans_in = 1'b1; tick();
        en = 1'b1; tick(); tick();
        chk("en_mid_high", int'(a_count_live), 0);
        hold_ans(1'b0, 1); hold_ans(1'b1, 1);
        chk("en_next_edge", int'(a_count_live), 1);
        hold_ans(1'b0, 1);
        rd_req = 1'b1; tick();
        chk("en_rd_count", int'(a_rd_count), 1);
        rd_req = 1'b0; tick();

        // Edge coincident with snapshot, then held request with no re-snapshot
        pulse_edges(5);
        chk("co_pre_count", int'(a_count_live), 5);
        ans_in = 1'b1; rd_req = 1'b1; tick();
        chk("co_ack1", int'(a_rd_ack), 1);
        chk("co_rd_count1", int'(a_rd_count), 5);
        chk("co_count_live", int'(a_count_live), 1);
        ans_in = 1'b0; tick();
        chk("co_ack2", int'(a_rd_ack), 1);
        chk("co_rd_count2", int'(a_rd_count), 5);
        ans_in = 1'b1; tick();
        chk("co_ack3", int'(a_rd_ack), 1);
        tick();
        chk("co_ack4", int'(a_rd_ack), 1);
        chk("co_rd_count4", int'(a_rd_count), 5);
        chk("co_live4", int'(a_count_live), 2);
        rd_req = 1'b0; ans_in = 1'b0; tick();
        chk("co_ack_drop", int'(a_rd_ack), 0);
        chk("co_rd_count_held", int'(a_rd_count), 5);

        // Reset in the middle of an acknowledged read
        pulse_edges(1);
        chk("mr_pre_count", int'(a_count_live), 3);
        rd_req = 1'b1; tick();
        chk("mr_rd_count", int'(a_rd_count), 3);
        pulse_edges(3);
        chk("mr_ack_held", int'(a_rd_ack), 1);
        chk("mr_counting", int'(a_count_live), 3);
        reset = 1'b1; tick();
        chk("mr_ack", int'(a_rd_ack), 0);
        chk("mr_rd_count0", int'(a_rd_count), 0);
        chk("mr_live0", int'(a_count_live), 0);
        reset = 1'b0; rd_req = 1'b0; tick();
        pulse_edges(2);
        rd_req = 1'b1; tick();
        chk("mr_new_ack", int'(a_rd_ack), 1);
        chk("mr_new_rd_count", int'(a_rd_count), 2);
        rd_req = 1'b0; tick();
        chk("mr_new_ack_drop", int'(a_rd_ack), 0);

        // Saturation: 17 edges into the 4-bit instance
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_edges(17);
        chk("sat4_live", int'(b_count_live), 15);
        chk("sat8_live", int'(a_count_live), 17);
        rd_req = 1'b1; tick();
        chk("sat4_rd_count", int'(b_rd_count), 15);
        chk("sat4_rd_ovf", int'(b_rd_ovf), 1);
        chk("sat8_rd_count", int'(a_rd_count), 17);
        chk("sat8_rd_ovf", int'(a_rd_ovf), 0);
        rd_req = 1'b0; tick();
        rd_req = 1'b1; tick();
        chk("sat4_rd2_count", int'(b_rd_count), 0);
        chk("sat4_rd2_ovf", int'(b_rd_ovf), 0);
        rd_req = 1'b0; tick();

        // High runs of 3, 7, 2 then read
        reset = 1'b1; tick(); reset = 1'b0;
        hold_ans(1'b1, 3); hold_ans(1'b0, 2);
        hold_ans(1'b1, 7); hold_ans(1'b0, 2);
        hold_ans(1'b1, 2); hold_ans(1'b0, 1);
        chk("rl_pre_max", int'(a_max_run), 0);
        rd_req = 1'b1; tick();
`ifdef MATCH_RUNLEN_EN
        exp_max = 7;
`else
        exp_max = 0;
`endif
        chk("rl_max8", int'(a_max_run), exp_max);
        chk("rl_max4", int'(b_max_run), exp_max);
        chk("rl_rd_count", int'(a_rd_count), 3);
        rd_req = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
